// File: rtl/salamander_pkg.sv
// Shared types for the Salamander ROM download front-end: loader FSM states,
// default ioctl indexes and the word entry queued towards SDRAM.
package salamander_pkg;

  localparam int unsigned ROM_INDEX_DEF   = 0;
  localparam int unsigned DIP_INDEX_DEF   = 254;
  // Widest word address a 27-bit ioctl byte address can produce.
  localparam int unsigned WORD_ADDR_MAX_W = 26;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } loaderState_t;

  typedef struct packed {
    logic [WORD_ADDR_MAX_W-1:0] addr;
    logic [15:0]                data;
  } loaderEntry_t;

endpackage

// File: rtl/rom_loader_fifo.sv
// Synchronous FIFO of packed ROM words waiting for their SDRAM write.
// A push while full is dropped unless a pop frees the slot in the same cycle.
module rom_loader_fifo
  import salamander_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  loaderEntry_t     din_i,
  output loaderEntry_t     dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  loaderEntry_t     mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush, doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign dout_o  = mem[rdPtr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/salamander_rom_loader.sv
// hps_io download front-end: packs ROM bytes into 16-bit SDRAM writes, latches DIP bytes.
// Define ROM_LOADER_CKSUM_EN to add the o_CKSUM running byte sum of the ROM image.
module salamander_rom_loader
  import salamander_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 25,
  parameter int ROM_INDEX  = ROM_INDEX_DEF,
  parameter int DIP_INDEX  = DIP_INDEX_DEF
) (
  input  logic              i_EMU_MCLK,
  input  logic              i_EMU_INITRST,
  input  logic [15:0]       ioctl_index,
  input  logic              ioctl_download,
  input  logic [26:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              ioctl_wr,
  output logic              ioctl_wait,
  output logic              o_SDR_REQ,
  output logic [ADDR_W-1:0] o_SDR_ADDR,
  output logic [15:0]       o_SDR_DATA,
  input  logic              i_SDR_ACK,
  output logic [63:0]       o_DIP,
  output logic              o_ROM_READY,
`ifdef ROM_LOADER_CKSUM_EN
  output logic [15:0]       o_CKSUM,
`endif
  output logic              o_OVERFLOW
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  loaderState_t      state_q, state_d;
  loaderEntry_t      fifoDin, fifoDout;
  logic [CNT_W-1:0]  fifoCount;
  logic              fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic              romSel, romWr, dipWr, padPush, startLoad;
  logic              half_q, req_q, wait_q, ready_q, overflow_q;
  logic [7:0]        latch_q;
  logic [ADDR_W-1:0] latchAddr_q, sdrAddr_q;
  logic [15:0]       sdrData_q;
  logic [7:0][7:0]   dip_q;
  logic              unusedAddrBits;

  assign romSel    = (ioctl_index == 16'(ROM_INDEX));
  assign romWr     = ioctl_wr && romSel && (state_q == LOAD);
  assign dipWr     = ioctl_wr && (ioctl_index == 16'(DIP_INDEX)) && (ioctl_addr < 27'd8);
  assign fifoPush  = (romWr && ioctl_addr[0]) || padPush;
  assign fifoPop   = req_q && i_SDR_ACK;
  assign startLoad = (state_q == IDLE) && (state_d == LOAD);
  assign unusedAddrBits = ^fifoDout.addr;

  rom_loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (i_EMU_MCLK),
    .rst    (i_EMU_INITRST),
    .push_i (fifoPush),
    .pop_i  (fifoPop),
    .din_i  (fifoDin),
    .dout_o (fifoDout),
    .count_o(fifoCount),
    .full_o (fifoFull),
    .empty_o(fifoEmpty)
  );

  // In FLUSH a dangling even byte is padded out before the drain check is allowed.
  always_comb begin
    state_d      = state_q;
    padPush      = 1'b0;
    fifoDin.addr = WORD_ADDR_MAX_W'(ioctl_addr[ADDR_W:1]);
    fifoDin.data = {ioctl_data, latch_q};
    case (state_q)
      IDLE:  if (ioctl_download && romSel) state_d = LOAD;
      LOAD:  if (!ioctl_download) state_d = FLUSH;
      FLUSH: begin
        if (half_q) begin
          padPush      = 1'b1;
          fifoDin.addr = WORD_ADDR_MAX_W'(latchAddr_q);
          fifoDin.data = {8'h00, latch_q};
        end else if (fifoEmpty && !req_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      state_q     <= IDLE;
      half_q      <= 1'b0;
      latch_q     <= '0;
      latchAddr_q <= '0;
      ready_q     <= 1'b0;
      overflow_q  <= 1'b0;
      wait_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= (fifoCount >= CNT_W'(FIFO_DEPTH - 2)) || (state_q == FLUSH);
      if (fifoPush && fifoFull && !fifoPop) overflow_q <= 1'b1;
      if (startLoad) ready_q <= 1'b0;
      else if (state_d == DONE) ready_q <= 1'b1;
      if (startLoad) begin
        half_q <= 1'b0;
      end else if (romWr) begin
        half_q <= !ioctl_addr[0];
        if (!ioctl_addr[0]) begin
          latch_q     <= ioctl_data;
          latchAddr_q <= ioctl_addr[ADDR_W:1];
        end
      end else if (padPush) begin
        half_q <= 1'b0;
      end
    end
  end

  // Address and data are captured when REQ rises so they cannot move until the ACK.
  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      req_q     <= 1'b0;
      sdrAddr_q <= '0;
      sdrData_q <= '0;
    end else if (fifoPop) begin
      req_q <= 1'b0;
    end else if (!req_q && !fifoEmpty) begin
      req_q     <= 1'b1;
      sdrAddr_q <= fifoDout.addr[ADDR_W-1:0];
      sdrData_q <= fifoDout.data;
    end
  end

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) dip_q <= '0;
    else if (dipWr) dip_q[ioctl_addr[2:0]] <= ioctl_data;
  end

`ifdef ROM_LOADER_CKSUM_EN
  logic [15:0] cksum_q;

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) cksum_q <= '0;
    else if (startLoad) cksum_q <= '0;
    else if (fifoPush && (!fifoFull || fifoPop))
      cksum_q <= cksum_q + 16'(fifoDin.data[15:8]) + 16'(fifoDin.data[7:0]);
  end

  assign o_CKSUM = cksum_q;
`endif

  assign ioctl_wait  = wait_q;
  assign o_SDR_REQ   = req_q;
  assign o_SDR_ADDR  = sdrAddr_q;
  assign o_SDR_DATA  = sdrData_q;
  assign o_DIP       = dip_q;
  assign o_ROM_READY = ready_q;
  assign o_OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_salamander_rom_loader.sv
// Randomized self-checking bench for salamander_rom_loader: an SDRAM responder records
// every write, and a byte-list reference model predicts the words and DIP register.
module tb_salamander_rom_loader;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ioctl_index = '0;
  logic        ioctl_download = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic        ioctl_wait;
  logic        o_SDR_REQ;
  logic [24:0] o_SDR_ADDR;
  logic [15:0] o_SDR_DATA;
  logic        i_SDR_ACK = 1'b0;
  logic [63:0] o_DIP;
  logic        o_ROM_READY;
  logic        o_OVERFLOW;
`ifdef ROM_LOADER_CKSUM_EN
  logic [15:0] o_CKSUM;
`endif

  int          checks = 0;
  int          passed = 0;
  logic [40:0] gotQ[$];
  logic [40:0] expQ[$];
  logic [7:0]  byteArr[64];
  logic [7:0]  dipModel[8];
  int          unstable = 0;
  bit          ackEnable = 1'b0;
  bit          randomAck = 1'b0;

  always #5 clk = ~clk;

  salamander_rom_loader #(.FIFO_DEPTH(DEPTH), .ADDR_W(25), .ROM_INDEX(0), .DIP_INDEX(254)) dut (
    .i_EMU_MCLK    (clk),
    .i_EMU_INITRST (rst),
    .ioctl_index   (ioctl_index),
    .ioctl_download(ioctl_download),
    .ioctl_addr    (ioctl_addr),
    .ioctl_data    (ioctl_data),
    .ioctl_wr      (ioctl_wr),
    .ioctl_wait    (ioctl_wait),
    .o_SDR_REQ     (o_SDR_REQ),
    .o_SDR_ADDR    (o_SDR_ADDR),
    .o_SDR_DATA    (o_SDR_DATA),
    .i_SDR_ACK     (i_SDR_ACK),
    .o_DIP         (o_DIP),
    .o_ROM_READY   (o_ROM_READY),
`ifdef ROM_LOADER_CKSUM_EN
    .o_CKSUM       (o_CKSUM),
`endif
    .o_OVERFLOW    (o_OVERFLOW)
  );

  // SDRAM model: records each request once, watches it stay stable, acks after a delay.
  initial begin : responder
    int          age;
    int          curDelay;
    logic [40:0] curWord;
    age = 0;
    curDelay = 2;
    curWord = '0;
    forever begin
      @(negedge clk);
      i_SDR_ACK = 1'b0;
      if (rst || !o_SDR_REQ) begin
        age = 0;
      end else begin
        age++;
        if (age == 1) begin
          curWord = {o_SDR_ADDR, o_SDR_DATA};
          gotQ.push_back(curWord);
          curDelay = randomAck ? int'($urandom_range(1, 4)) : 2;
        end else if ({o_SDR_ADDR, o_SDR_DATA} != curWord) begin
          unstable++;
        end
        if (ackEnable && age >= curDelay) i_SDR_ACK = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] idx, input logic [26:0] addr, input logic [7:0] data,
                               input bit respectWait);
    int guard;
    guard = 0;
    ioctl_index = idx;
    if (respectWait) begin
      while (ioctl_wait && guard < 500) begin
        tick();
        guard++;
      end
      if (guard >= 500) checkOutput("waitTimeout", 64'd1, 64'd0);
    end
    ioctl_addr = addr;
    ioctl_data = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic romDownload(input int n, input int base, input bit respectWait);
    gotQ.delete();
    unstable = 0;
    ioctl_index = 16'd0;
    ioctl_download = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < n; i++) applyStimulus(16'd0, 27'(base + i), byteArr[i], respectWait);
  endtask

  task automatic endDownload();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic waitReady(input string tag);
    int guard;
    guard = 0;
    while (!o_ROM_READY && guard < 3000) begin
      tick();
      guard++;
    end
    checkOutput(tag, 64'(o_ROM_READY), 64'd1);
  endtask

  task automatic waitWrites(input int n);
    int guard;
    guard = 0;
    while (gotQ.size() < n && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) checkOutput("writeTimeout", 64'(gotQ.size()), 64'(n));
  endtask

  // Reference: byte i and i+1 of an even-based image form word (base+i)/2, odd tail padded with 0.
  task automatic buildExpected(input int n, input int base, input int limit);
    logic [7:0] hi;
    expQ.delete();
    for (int i = 0; i < n; i += 2) begin
      hi = (i + 1 < n) ? byteArr[i + 1] : 8'h00;
      if (expQ.size() < limit) expQ.push_back({25'((base + i) / 2), hi, byteArr[i]});
    end
  endtask

  function automatic logic [15:0] byteSum(input int n);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = s + 16'(byteArr[i]);
    return s;
  endfunction

  task automatic compareWrites(input string tag);
    checkOutput({tag, "_count"}, 64'(gotQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      checkOutput($sformatf("%s_w%0d", tag, i), 64'(gotQ[i]), 64'(expQ[i]));
    checkOutput({tag, "_stable"}, 64'(unstable), 64'd0);
  endtask

  function automatic logic [63:0] dipPacked();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = dipModel[i];
    return v;
  endfunction

  initial begin : main
    int n;
    int base;
    int a;
    for (int i = 0; i < 8; i++) dipModel[i] = 8'h00;
    repeat (3) tick();
    checkOutput("rst_req", 64'(o_SDR_REQ), 64'd0);
    checkOutput("rst_addrData", 64'({o_SDR_ADDR, o_SDR_DATA}), 64'd0);
    checkOutput("rst_ready", 64'(o_ROM_READY), 64'd0);
    checkOutput("rst_wait", 64'(ioctl_wait), 64'd0);
    checkOutput("rst_overflow", 64'(o_OVERFLOW), 64'd0);
    checkOutput("rst_dip", o_DIP, 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] four-byte ROM image");
    ackEnable = 1'b1;
    randomAck = 1'b0;
    byteArr[0] = 8'h11; byteArr[1] = 8'h22; byteArr[2] = 8'h33; byteArr[3] = 8'h44;
    romDownload(4, 0, 1'b1);
    endDownload();
    waitReady("t1_ready");
    buildExpected(4, 0, 1000);
    compareWrites("t1");
`ifdef ROM_LOADER_CKSUM_EN
    checkOutput("t1_cksum", 64'(o_CKSUM), 64'h00AA);
`endif

    $display("[TB] odd-length ROM image");
    for (int i = 0; i < 5; i++) byteArr[i] = 8'(i + 1);
    romDownload(5, 0, 1'b1);
    endDownload();
    waitWrites(3);
    checkOutput("t2_readyBeforeLastAck", 64'(o_ROM_READY), 64'd0);
    waitReady("t2_ready");
    buildExpected(5, 0, 1000);
    compareWrites("t2");
`ifdef ROM_LOADER_CKSUM_EN
    checkOutput("t2_cksum", 64'(o_CKSUM), 64'(byteSum(5)));
`endif

    $display("[TB] throttle with ACK withheld");
    ackEnable = 1'b0;
    for (int i = 0; i < 12; i++) byteArr[i] = 8'($urandom);
    romDownload(12, 0, 1'b0);
    repeat (3) tick();
    checkOutput("t3_waitHigh", 64'(ioctl_wait), 64'd1);
    checkOutput("t3_noOverflow", 64'(o_OVERFLOW), 64'd0);
    ackEnable = 1'b1;
    waitWrites(6);
    repeat (4) tick();
    checkOutput("t3_waitLow", 64'(ioctl_wait), 64'd0);
    endDownload();
    waitReady("t3_ready");
    buildExpected(12, 0, 1000);
    compareWrites("t3");

    $display("[TB] overflow on full FIFO");
    ackEnable = 1'b0;
    for (int i = 0; i < 20; i++) byteArr[i] = 8'($urandom);
    romDownload(20, 0, 1'b0);
    tick();
    checkOutput("t4_overflow", 64'(o_OVERFLOW), 64'd1);
    ackEnable = 1'b1;
    endDownload();
    waitReady("t4_ready");
    buildExpected(20, 0, DEPTH);
    compareWrites("t4");
    checkOutput("t4_overflowSticky", 64'(o_OVERFLOW), 64'd1);

    $display("[TB] reset mid-download");
    ackEnable = 1'b0;
    for (int i = 0; i < 6; i++) byteArr[i] = 8'($urandom);
    romDownload(6, 0, 1'b0);
    repeat (3) tick();
    checkOutput("t6_reqBefore", 64'(o_SDR_REQ), 64'd1);
    rst = 1'b1;
    ioctl_download = 1'b0;
    #1;
    checkOutput("t6_req", 64'(o_SDR_REQ), 64'd0);
    checkOutput("t6_ready", 64'(o_ROM_READY), 64'd0);
    checkOutput("t6_overflow", 64'(o_OVERFLOW), 64'd0);
    tick();
    rst = 1'b0;
    ackEnable = 1'b1;
    gotQ.delete();
    repeat (10) tick();
    checkOutput("t6_fifoEmpty", 64'(gotQ.size()), 64'd0);
    checkOutput("t6_wait", 64'(ioctl_wait), 64'd0);

    $display("[TB] DIP bytes");
    gotQ.delete();
    ioctl_index = 16'd254;
    ioctl_download = 1'b1;
    tick();
    applyStimulus(16'd254, 27'd2, 8'hA5, 1'b0);
    dipModel[2] = 8'hA5;
    tick();
    checkOutput("t5_dipByte2", 64'(o_DIP[23:16]), 64'hA5);
    applyStimulus(16'd254, 27'd9, 8'hFF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, 7));
      n = int'($urandom_range(0, 255));
      applyStimulus(16'd254, 27'(a), 8'(n), 1'b0);
      dipModel[a] = 8'(n);
    end
    applyStimulus(16'd5, 27'd1, 8'h77, 1'b0);
    ioctl_download = 1'b0;
    repeat (4) tick();
    checkOutput("t5_dip", o_DIP, dipPacked());
    checkOutput("t5_noWrites", 64'(gotQ.size()), 64'd0);
    checkOutput("t5_wait", 64'(ioctl_wait), 64'd0);

    $display("[TB] random ROM images");
    randomAck = 1'b1;
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, 24));
      base = 2 * int'($urandom_range(0, 5000));
      for (int i = 0; i < n; i++) byteArr[i] = 8'($urandom);
      romDownload(n, base, 1'b1);
      endDownload();
      waitReady($sformatf("rnd%0d_ready", t));
      buildExpected(n, base, 1000);
      compareWrites($sformatf("rnd%0d", t));
`ifdef ROM_LOADER_CKSUM_EN
      checkOutput($sformatf("rnd%0d_cksum", t), 64'(o_CKSUM), 64'(byteSum(n)));
`endif
    end
    checkOutput("final_dip", o_DIP, dipPacked());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
